acc_alu_n: RTL and testbench

ACC_ALU_N -- requirements
Module: acc_alu_n

---
 rtl/acc_alu_n.sv | 175 +++++++++++++++++
 tb/tb_acc_alu_n.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_alu_n.sv
// Accumulator ALU: single-cycle arithmetic/logic/shift ops on register A,
// plus an unsigned shift-add multiply that leaves the product in {h, A}.
module acc_alu_n #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] h,
   output logic             n,
   output logic             z,
   output logic             c,
   output logic             v,
   output logic             busy,
   output logic             done
);

   localparam logic [3:0] OP_PASS = 4'd1;
   localparam logic [3:0] OP_ADD  = 4'd2;
   localparam logic [3:0] OP_SUB  = 4'd3;
   localparam logic [3:0] OP_AND  = 4'd4;
   localparam logic [3:0] OP_OR   = 4'd5;
   localparam logic [3:0] OP_XOR  = 4'd6;
   localparam logic [3:0] OP_ADC  = 4'd7;
   localparam logic [3:0] OP_SBC  = 4'd8;
   localparam logic [3:0] OP_SHL  = 4'd9;
   localparam logic [3:0] OP_SHR  = 4'd10;
   localparam logic [3:0] OP_ASR  = 4'd11;
   localparam logic [3:0] OP_MUL  = 4'd12;

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

   state_t           state_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] h_reg;
   logic [WIDTH-1:0] mcand_reg;
   logic [CW-1:0]    cnt_reg;
   logic             c_reg;
   logic             v_reg;
   logic             busy_reg;
   logic             done_reg;

   logic             cin;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH:0]   mstep;
   logic [WIDTH-1:0] a_next;
   logic             c_next;
   logic             v_next;

   // One adder and one subtractor serve both the plain and carry-chained forms.
   assign cin   = ((op == OP_ADC) || (op == OP_SBC)) ? c_reg : 1'b0;
   assign sum   = {1'b0, a_reg} + {1'b0, din} + {{WIDTH{1'b0}}, cin};
   assign diff  = {1'b0, a_reg} - {1'b0, din} - {{WIDTH{1'b0}}, cin};
   assign mstep = {1'b0, h_reg} + (a_reg[0] ? {1'b0, mcand_reg} : '0);

   always_comb begin
      a_next = a_reg;
      c_next = c_reg;
      v_next = v_reg;
      case (op)
         OP_PASS: begin
            a_next = din;
            v_next = 1'b0;
         end
         OP_ADD, OP_ADC: begin
            a_next = sum[WIDTH-1:0];
            c_next = sum[WIDTH];
            v_next = (a_reg[WIDTH-1] == din[WIDTH-1]) && (sum[WIDTH-1] != a_reg[WIDTH-1]);
         end
         OP_SUB, OP_SBC: begin
            a_next = diff[WIDTH-1:0];
            c_next = diff[WIDTH];
            v_next = (a_reg[WIDTH-1] != din[WIDTH-1]) && (diff[WIDTH-1] != a_reg[WIDTH-1]);
         end
         OP_AND: begin
            a_next = a_reg & din;
            v_next = 1'b0;
         end
         OP_OR: begin
            a_next = a_reg | din;
            v_next = 1'b0;
         end
         OP_XOR: begin
            a_next = a_reg ^ din;
            v_next = 1'b0;
         end
         OP_SHL: begin
            a_next = {a_reg[WIDTH-2:0], 1'b0};
            c_next = a_reg[WIDTH-1];
            v_next = 1'b0;
         end
         OP_SHR: begin
            a_next = {1'b0, a_reg[WIDTH-1:1]};
            c_next = a_reg[0];
            v_next = 1'b0;
         end
         OP_ASR: begin
            a_next = {a_reg[WIDTH-1], a_reg[WIDTH-1:1]};
            c_next = a_reg[0];
            v_next = 1'b0;
         end
         default: ;
      endcase
   end

   // A doubles as the multiplier: its bits are consumed from the bottom while
   // product bits shift in from h, so {h, A} holds the product after WIDTH steps.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg <= S_IDLE;
         a_reg     <= '0;
         h_reg     <= '0;
         mcand_reg <= '0;
         cnt_reg   <= '0;
         c_reg     <= 1'b0;
         v_reg     <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (en) begin
                  if (op == OP_MUL) begin
                     mcand_reg <= din;
                     h_reg     <= '0;
                     cnt_reg   <= '0;
                     busy_reg  <= 1'b1;
                     state_reg <= S_RUN;
                  end else begin
                     a_reg <= a_next;
                     c_reg <= c_next;
                     v_reg <= v_next;
                  end
               end
            end
            S_RUN: begin
               h_reg   <= mstep[WIDTH:1];
               a_reg   <= {mstep[0], a_reg[WIDTH-1:1]};
               cnt_reg <= cnt_reg + CW'(1);
               if (cnt_reg == CW'(WIDTH - 1)) begin
                  c_reg     <= (mstep[WIDTH:1] != '0);
                  v_reg     <= 1'b0;
                  done_reg  <= 1'b1;
                  state_reg <= S_FIN;
               end
            end
            S_FIN: begin
               busy_reg  <= 1'b0;
               state_reg <= S_IDLE;
            end
            default: begin
               busy_reg  <= 1'b0;
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   assign a    = a_reg;
   assign h    = h_reg;
   assign n    = a_reg[WIDTH-1];
   assign z    = (a_reg == '0);
   assign c    = c_reg;
   assign v    = v_reg;
   assign busy = busy_reg;
   assign done = done_reg;

endmodule

// File: tb/tb_acc_alu_n.sv
// Scoreboard bench for acc_alu_n (WIDTH=8): directed ops queue their expected
// register/flag state; a negedge monitor pops and compares.
module tb_acc_alu_n;

   logic       clock;
   logic       reset;
   logic       en;
   logic [3:0] op;
   logic [7:0] din;
   logic [7:0] a;
   logic [7:0] h;
   logic       n, z, c, v, busy, done;

   acc_alu_n #(.WIDTH(8)) dut (
      .clock(clock),
      .reset(reset),
      .en   (en),
      .op   (op),
      .din  (din),
      .a    (a),
      .h    (h),
      .n    (n),
      .z    (z),
      .c    (c),
      .v    (v),
      .busy (busy),
      .done (done)
   );

   typedef struct {
      int         due;
      string      name;
      logic [7:0] a;
      logic [7:0] h;
      logic       n, z, c, v, busy, done;
   } exp_t;

   exp_t exp_q[$];
   exp_t mul_q[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   cyc         = 0;
   int   busy_cnt    = 0;
   int   done_cnt    = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   function automatic exp_t mk(input string nm, input logic [7:0] ea, input logic [7:0] eh,
                               input logic ec, input logic ev, input logic eb, input logic ed);
      exp_t x;
      x.due  = 0;
      x.name = nm;
      x.a    = ea;
      x.h    = eh;
      x.n    = ea[7];
      x.z    = (ea == 8'h00);
      x.c    = ec;
      x.v    = ev;
      x.busy = eb;
      x.done = ed;
      return x;
   endfunction

   task automatic check(input exp_t x);
      vectors++;
      if (a !== x.a || h !== x.h || n !== x.n || z !== x.z || c !== x.c || v !== x.v ||
          busy !== x.busy || done !== x.done) begin
         miscompares++;
         $display("FAIL %s: got a=%02h h=%02h nzcv=%b%b%b%b busy=%b done=%b, expected a=%02h h=%02h nzcv=%b%b%b%b busy=%b done=%b",
                  x.name, a, h, n, z, c, v, busy, done, x.a, x.h, x.n, x.z, x.c, x.v, x.busy, x.done);
      end else begin
         $display("vec %-14s a=%02h h=%02h nzcv=%b%b%b%b busy=%b done=%b ok",
                  x.name, a, h, n, z, c, v, busy, done);
      end
   endtask

   // Monitor: single-cycle results are due one edge after acceptance; the
   // multiply result is popped whenever the DUT raises done.
   always @(negedge clock) begin
      if (busy) busy_cnt++;
      if (done) begin
         done_cnt++;
         if (mul_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_done: got done=1 a=%02h h=%02h, expected no done pulse", a, h);
         end else begin
            check(mul_q.pop_front());
         end
      end
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) check(exp_q.pop_front());
   end

   // Called at posedge+1; the following edge is the acceptance edge.
   task automatic do_op(input logic e, input logic [3:0] o, input logic [7:0] d, input string nm,
                        input logic [7:0] ea, input logic [7:0] eh, input logic ec, input logic ev);
      exp_t x;
      en  = e;
      op  = o;
      din = d;
      x = mk(nm, ea, eh, ec, ev, 1'b0, 1'b0);
      x.due = cyc + 1;
      exp_q.push_back(x);
      @(posedge clock);
      #1;
      en = 1'b0;
   endtask

   task automatic expect_now(input string nm, input logic [7:0] ea, input logic [7:0] eh,
                             input logic ec, input logic ev);
      exp_t x;
      x = mk(nm, ea, eh, ec, ev, 1'b0, 1'b0);
      x.due = cyc;
      exp_q.push_back(x);
   endtask

   task automatic count_check(input string nm, input int got, input int want);
      vectors++;
      if (got != want) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, want);
      end else begin
         $display("vec %-14s count=%0d ok", nm, got);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   b0;
      int   d0;
      bit   seen;
      exp_t x;

      reset = 1'b1;
      en    = 1'b0;
      op    = 4'd0;
      din   = 8'h00;
      @(posedge clock);
      #1;
      expect_now("reset", 8'h00, 8'h00, 1'b0, 1'b0);
      @(posedge clock);
      #1;
      reset = 1'b0;

      do_op(1, 4'd1,  8'h7F, "pass_7f",   8'h7F, 8'h00, 0, 0);
      do_op(1, 4'd2,  8'h01, "add_ovf",   8'h80, 8'h00, 0, 1);
      do_op(1, 4'd1,  8'h05, "pass_05",   8'h05, 8'h00, 0, 0);
      do_op(1, 4'd3,  8'h06, "sub_borrow",8'hFF, 8'h00, 1, 0);
      do_op(1, 4'd8,  8'h00, "sbc_00",    8'hFE, 8'h00, 0, 0);
      do_op(1, 4'd1,  8'hFF, "pass_ff",   8'hFF, 8'h00, 0, 0);
      do_op(1, 4'd2,  8'h01, "add_carry", 8'h00, 8'h00, 1, 0);
      do_op(1, 4'd7,  8'h00, "adc_00",    8'h01, 8'h00, 0, 0);
      do_op(1, 4'd1,  8'h81, "pass_81a",  8'h81, 8'h00, 0, 0);
      do_op(1, 4'd9,  8'h00, "shl",       8'h02, 8'h00, 1, 0);
      do_op(1, 4'd1,  8'h81, "pass_81b",  8'h81, 8'h00, 1, 0);
      do_op(1, 4'd11, 8'h00, "asr",       8'hC0, 8'h00, 1, 0);
      do_op(1, 4'd5,  8'h0F, "or_0f",     8'hCF, 8'h00, 1, 0);
      do_op(1, 4'd6,  8'hCF, "xor_cf",    8'h00, 8'h00, 1, 0);
      do_op(1, 4'd1,  8'h81, "pass_81c",  8'h81, 8'h00, 1, 0);
      do_op(1, 4'd10, 8'h00, "shr",       8'h40, 8'h00, 1, 0);
      do_op(1, 4'd1,  8'hF0, "pass_f0",   8'hF0, 8'h00, 1, 0);
      do_op(1, 4'd4,  8'h3C, "and_3c",    8'h30, 8'h00, 1, 0);
      do_op(1, 4'd13, 8'hFF, "op13_nop",  8'h30, 8'h00, 1, 0);
      do_op(0, 4'd1,  8'h55, "en_low",    8'h30, 8'h00, 1, 0);
      do_op(1, 4'd1,  8'h80, "pass_80",   8'h80, 8'h00, 1, 0);
      do_op(1, 4'd3,  8'h01, "sub_ovf",   8'h7F, 8'h00, 0, 1);
      do_op(1, 4'd15, 8'h12, "op15_nop",  8'h7F, 8'h00, 0, 1);
      do_op(1, 4'd1,  8'hFF, "pass_ff2",  8'hFF, 8'h00, 0, 0);

      // MUL 0xFF * 0xFF with an ADD held on the inputs the whole time.
      b0 = busy_cnt;
      d0 = done_cnt;
      mul_q.push_back(mk("mul_ff_ff", 8'h01, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b1));
      en  = 1'b1;
      op  = 4'd12;
      din = 8'hFF;
      @(posedge clock);
      #1;
      op  = 4'd2;
      din = 8'h01;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(posedge clock);
         #1;
         if (done) seen = 1'b1;
      end
      if (!seen) begin
         vectors++;
         miscompares++;
         $display("FAIL mul_timeout: got no done within 40 cycles, expected done");
         if (mul_q.size() > 0) x = mul_q.pop_front();
      end
      @(posedge clock);
      #1;
      en = 1'b0;
      expect_now("after_mul", 8'h01, 8'hFE, 1'b1, 1'b0);
      @(posedge clock);
      #1;
      count_check("mul_busy_cyc", busy_cnt - b0, 9);
      count_check("mul_done_cnt", done_cnt - d0, 1);

      // Reset mid-multiply aborts with no done pulse.
      do_op(1, 4'd1, 8'h10, "pass_10", 8'h10, 8'hFE, 1, 0);
      d0 = done_cnt;
      en  = 1'b1;
      op  = 4'd12;
      din = 8'h10;
      @(posedge clock);
      #1;
      en = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      #1;
      expect_now("reset_mid_mul", 8'h00, 8'h00, 1'b0, 1'b0);
      @(posedge clock);
      #1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      do_op(1, 4'd1, 8'h22, "pass_22", 8'h22, 8'h00, 0, 0);
      repeat (12) @(posedge clock);
      #1;
      count_check("abort_done", done_cnt - d0, 0);

      if (exp_q.size() != 0 || mul_q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain: got %0d/%0d pending entries, expected 0/0", exp_q.size(), mul_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
